// File: rtl/qpsk_symbol_mapper.sv
// Byte FIFO feeding a Gray-coded QPSK mapper (Q2.13). Emits one symbol per
// SYM_PERIOD clocks with a one-cycle read strobe, inserting zero filler when starved.
module qpsk_symbol_mapper #(
   parameter int          SYM_PERIOD = 3,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] AMP        = 16'h16A1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  data_in,
   input  logic        data_valid,
   output logic        data_ready,
   output logic [15:0] sym_i,
   output logic [15:0] sym_q,
   output logic        read,
   output logic        underflow
);
   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam int          CW      = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;
   localparam logic [CW-1:0] LAST  = CW'(SYM_PERIOD - 1);
   localparam logic [AW:0] FULL    = (AW + 1)'(FIFO_DEPTH);
   localparam logic [15:0] NEG_AMP = ~AMP + 16'd1;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count, count_nxt;
   logic [CW-1:0] slot_cnt;
   logic [1:0]    pair_cnt;
   logic [5:0]    shift;
   logic [1:0]    pair;
   logic          slot, empty, push, pop;

   assign slot  = (slot_cnt == '0);
   assign empty = (count == '0);
   assign push  = data_valid && data_ready;
   // Pop decision uses the pre-edge count, so a same-edge push never bypasses.
   assign pop   = slot && (pair_cnt == 2'd0) && !empty;
   assign pair  = pop ? mem[rd_ptr][7:6] : shift[5:4];

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + (AW + 1)'(1);
         2'b01:   count_nxt = count - (AW + 1)'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         data_ready <= 1'b1;
         slot_cnt   <= '0;
         pair_cnt   <= 2'd0;
         shift      <= 6'd0;
         sym_i      <= 16'd0;
         sym_q      <= 16'd0;
         read       <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count      <= count_nxt;
         data_ready <= (count_nxt != FULL);
         slot_cnt   <= (slot_cnt == LAST) ? '0 : slot_cnt + CW'(1);
         read       <= slot;
         underflow  <= 1'b0;
         if (slot) begin
            if (pop || pair_cnt != 2'd0) begin
               sym_i    <= pair[1] ? NEG_AMP : AMP;
               sym_q    <= pair[0] ? NEG_AMP : AMP;
               shift    <= pop ? mem[rd_ptr][5:0] : {shift[3:0], 2'b00};
               pair_cnt <= pair_cnt + 2'd1;
            end else begin
               sym_i     <= 16'd0;
               sym_q     <= 16'd0;
               underflow <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_qpsk_symbol_mapper.sv
// Directed bench for qpsk_symbol_mapper: cadence, mapping, FIFO backpressure,
// slot-edge push and mid-byte reset.
module tb_qpsk_symbol_mapper;
   localparam logic [15:0] P = 16'h16A1;
   localparam logic [15:0] N = 16'hE95F;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  data_in = 8'h00;
   logic        data_valid = 1'b0;
   logic        data_ready;
   logic [15:0] sym_i, sym_q;
   logic        read, underflow;

   qpsk_symbol_mapper dut (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .data_ready(data_ready), .sym_i(sym_i), .sym_q(sym_q),
      .read(read), .underflow(underflow)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // Waits for the next strobe (sampled on negedge); n = negedges waited.
   task automatic strobe(output logic [15:0] i, output logic [15:0] q,
                         output logic uf, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (read !== 1'b1 && n < 40);
      if (read !== 1'b1) chk("strobe_timeout", {31'd0, read}, 32'd1);
      i  = sym_i;
      q  = sym_q;
      uf = underflow;
   endtask

   task automatic push1(input logic [7:0] b);
      data_in    = b;
      data_valid = 1'b1;
      @(posedge clk);
      #1 data_valid = 1'b0;
   endtask

   function automatic logic [31:0] map(input logic [7:0] b, input int k);
      logic [1:0] p;
      p = b[7 - 2*k -: 2];
      return {p[1] ? N : P, p[0] ? N : P};
   endfunction

   logic [15:0] si, sq;
   logic        uf;
   int          n;
   logic [15:0] t1b_i [4] = '{P, P, N, N};
   logic [15:0] t1b_q [4] = '{P, N, P, N};
   logic [7:0]  fbytes [6] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
   int          idx, idx_at_full;
   logic        rdy;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_sym_i", {16'd0, sym_i}, 32'd0);
      chk("rst_sym_q", {16'd0, sym_q}, 32'd0);
      chk("rst_read", {31'd0, read}, 32'd0);
      chk("rst_uf", {31'd0, underflow}, 32'd0);
      chk("rst_ready", {31'd0, data_ready}, 32'd1);
      @(negedge clk);
      reset = 1'b0;

      // Idle: first strobe after first edge, then every 3 clocks with filler
      strobe(si, sq, uf, n);
      chk("idle_first_gap", n, 32'd1);
      chk("idle_uf0", {31'd0, uf}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         strobe(si, sq, uf, n);
         chk("idle_gap", n, 32'd3);
         chk("idle_sym", {si, sq}, 32'd0);
         chk("idle_uf", {31'd0, uf}, 32'd1);
      end
      @(negedge clk);
      chk("idle_read_low", {31'd0, read}, 32'd0);
      strobe(si, sq, uf, n);

      // Single byte 0x1B
      push1(8'h1B);
      for (int k = 0; k < 4; k++) begin
         strobe(si, sq, uf, n);
         chk("b1b_gap", n, 32'd3);
         chk("b1b_i", {16'd0, si}, {16'd0, t1b_i[k]});
         chk("b1b_q", {16'd0, sq}, {16'd0, t1b_q[k]});
         chk("b1b_uf", {31'd0, uf}, 32'd0);
      end
      strobe(si, sq, uf, n);
      chk("b1b_fill_sym", {si, sq}, 32'd0);
      chk("b1b_fill_uf", {31'd0, uf}, 32'd1);

      // All-zero byte
      push1(8'h00);
      for (int k = 0; k < 4; k++) begin
         strobe(si, sq, uf, n);
         chk("b00_sym", {si, sq}, {P, P});
         chk("b00_uf", {31'd0, uf}, 32'd0);
      end
      strobe(si, sq, uf, n);
      chk("b00_fill_uf", {31'd0, uf}, 32'd1);

      // Full FIFO with a continuous source
      idx = 0;
      idx_at_full = -1;
      fork
         begin
            for (int c = 0; c < 200 && idx < 6; c++) begin
               data_in    = fbytes[idx];
               data_valid = 1'b1;
               rdy        = data_ready;
               if (!rdy && idx_at_full < 0) idx_at_full = idx;
               @(posedge clk);
               if (rdy) idx++;
               @(negedge clk);
            end
            data_valid = 1'b0;
         end
         begin
            logic [15:0] ci, cq;
            logic        cu;
            int          cn;
            for (int k = 0; k < 24; k++) begin
               strobe(ci, cq, cu, cn);
               chk("full_sym", {ci, cq}, map(fbytes[k/4], k % 4));
               chk("full_uf", {31'd0, cu}, 32'd0);
            end
         end
      join
      chk("full_accepted", idx, 32'd6);
      chk("full_first_stall", idx_at_full, 32'd5);
      strobe(si, sq, uf, n);
      chk("full_drain_uf", {31'd0, uf}, 32'd1);

      // Push coincident with slot edge into empty FIFO
      @(negedge clk);
      @(negedge clk);
      push1(8'hC6);
      strobe(si, sq, uf, n);
      chk("edge_gap", n, 32'd1);
      chk("edge_fill_sym", {si, sq}, 32'd0);
      chk("edge_fill_uf", {31'd0, uf}, 32'd1);
      strobe(si, sq, uf, n);
      chk("edge_s0", {si, sq}, {N, N});
      strobe(si, sq, uf, n);
      chk("edge_s1", {si, sq}, {P, P});
      strobe(si, sq, uf, n);
      chk("edge_s2", {si, sq}, {P, N});
      strobe(si, sq, uf, n);
      chk("edge_s3", {si, sq}, {N, P});
      strobe(si, sq, uf, n);
      chk("edge_drain_uf", {31'd0, uf}, 32'd1);

      // Reset mid-byte with two bytes queued
      push1(8'hFF);
      push1(8'h55);
      push1(8'hAA);
      strobe(si, sq, uf, n);
      chk("mid_s0", {si, sq}, {N, N});
      strobe(si, sq, uf, n);
      chk("mid_s1", {si, sq}, {N, N});
      reset = 1'b1;
      #1;
      chk("mid_rst_sym", {si, sq} & 32'd0 | {sym_i, sym_q}, 32'd0);
      chk("mid_rst_read", {31'd0, read}, 32'd0);
      chk("mid_rst_ready", {31'd0, data_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      strobe(si, sq, uf, n);
      chk("mid_restart_gap", n, 32'd1);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) strobe(si, sq, uf, n);
         chk("mid_after_sym", {si, sq}, 32'd0);
         chk("mid_after_uf", {31'd0, uf}, 32'd1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
